spi_main_arb: RTL
=================

// Module: spi_main_arb
// PURPOSE
//   SPI main-side controller that shares one spi_sub link between NUM_REQ on-chip requesters.
//   Round-robin arbitration picks one request at a time.
//   For each request the block serializes a 44-bit {op,addr,data} frame on mosi and waits the sub's one-cycle memory access.
//   It then deserializes the 44-bit reply from miso and returns it, tagged with the requester id.
//   Sits between on-chip masters and the spi_sub register/memory bridge.
// PARAMETERS
//   NUM_REQ   2  number of requesters (2..8)
//   GAP_CYC   2  minimum sclk posedges with cs_n high between frames (>=1)
// PORTS
//   sclk      in   1            single clock; state updates on posedge; cs_n and mosi are launched on negedge
//   rst       in   1            synchronous, active-high reset (sampled on posedge sclk)
//   req_valid in   NUM_REQ      per-requester request pending
//   req_op    in   NUM_REQ x 2  op: 00 read, 01 write (other codes passed through uninterpreted)
//   req_addr  in   NUM_REQ x 10 target address
//   req_wdata in   NUM_REQ x 32 write data (ignored by sub on reads; sent as-is)
//   req_ready out  NUM_REQ      one-hot accept; a request transfers on the posedge where valid&ready
//   rsp_valid out  1            1-cycle pulse: reply available
//   rsp_id    out  $clog2(NUM_REQ) index of the requester that owns the reply
//   rsp_data  out  44           received frame {op,addr,data}
//   rsp_err   out  1            echo mismatch (SPI_MAIN_ECHO_CHK_EN only; else tied 0)
//   busy      out  1            frame or gap in progress
//   cs_n      out  1            SPI chip select, active low
//   mosi      out  1            main->sub serial data, MSB first
//   miso      in   1            sub->main serial data, MSB first, sampled on posedge
// BEHAVIOUR
//   Reset values: cs_n=1, mosi=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, RR pointer=0.
//   States: IDLE -> TX -> ACC -> RX -> GAP -> IDLE.
//   IDLE:
//     - req_ready is combinational: grant_i & (state==IDLE) & (gap_cnt==0).
//     - Priority order starts at the RR pointer. After a grant, the pointer = granted index + 1 (wraps at NUM_REQ).
//     - The transfer posedge G latches the frame {op,addr,data} and the id, then the state moves to TX.
//   TX:
//     - Negedge after G: cs_n=0, mosi=frame[43].
//     - At negedges N1..N44, mosi=frame[43..0]; the sub samples these at posedges P1..P44.
//     - At N45, mosi=0 and stays 0 until the next frame.
//   ACC: posedge P45 is the sub's memory-access cycle. Nothing is sampled.
//   RX:
//     - At P46..P89, miso is shifted into rx[43..0].
//     - At P89, rsp_data/rsp_id are registered and rsp_valid=1 for exactly one cycle.
//   GAP:
//     - cs_n goes high on the negedge after P89.
//     - The block holds for GAP_CYC posedges, then returns to IDLE.
//   Latency: grant posedge G to rsp_valid high = 89 posedges. One frame outstanding at most.
//   Payload rules:
//     - The requester must hold payload stable while valid & !ready.
//     - Deasserting valid before the grant withdraws the request without side effects.
//   Simultaneous valids: the RR order guarantees each requester is served within NUM_REQ frames.
//   Reset mid-frame:
//     - The abort takes effect at the posedge where rst=1; no rsp_valid is issued.
//     - Next negedge: cs_n=1, mosi=0. State returns to IDLE and the pointer to 0.
//     - The GAP counter is loaded to GAP_CYC, so the sub sees a clean deselect.
//   Counters: 6-bit bit counter, wraps only via state change; no arithmetic on data.
// CONFIGURATION
//   SPI_MAIN_ECHO_CHK_EN defined:
//     - At P89, compare rx with the sent frame. Writes (op 01) must match all 44 bits.
//     - Reads (op 00) must match bits [43:32].
//     - Other ops: no check.
//     - rsp_err is valid with rsp_valid and is 0 otherwise.
//   Not defined: no compare logic, rsp_err tied 0.
// STRUCTURE
//   spi_pkg:
//     - FRAME_W=44, OP_W=2, ADDR_W=10, DATA_W=32.
//     - OP_READ=2'b00, OP_WRITE=2'b01.
//     - spi_frame_t packed struct {op,addr,data}.
//     - spi_main_state_e {IDLE,TX,ACC,RX,GAP}.
//   Sub-module spi_rr_arb: NUM_REQ round-robin arbiter (req vector, advance pulse -> one-hot grant, index).
//   The serial engine and negedge output flops stay in spi_main_arb.
// TESTING (bench instantiates spi_sub with a 1K x 32 memory model on data_o/data_i)
//   1 Req0 write op=01 addr=0x010 data=0xDEADBEEF.
//     -> mosi stream 0x410DEADBEEF. Sub w_en with addr=0x010, data_o=DEADBEEF.
//     -> rsp_data=0x410DEADBEEF, rsp_id=0, rsp_valid 89 posedges after grant.
//   2 Then req1 read addr=0x010.
//     -> mosi stream 0x01000000000. rsp_data[43:32]=0x010, rsp_data[31:0]=0xDEADBEEF, rsp_id=1.
//   3 Req0 and req1 valid in the same cycle, both held for 3 requests each.
//     -> grants 0,1,0,1,0,1. cs_n high >=2 posedges between frames.
//   4 rst=1 at P20 of a write to 0x020.
//     -> cs_n=1 next negedge, no rsp_valid, no w_en. A following write to 0x020 data 0x12345678 completes correctly.
//   5 Sub model forced to corrupt the echoed address (macro defined).
//     -> rsp_err=1 with rsp_valid. Clean frame -> rsp_err=0.
//   6 Write 0x020=0x12345678, then read 0x010 and 0x020.
//     -> 0xDEADBEEF and 0x12345678 (no cross-address corruption).

Source files
------------

// File: rtl/spi_pkg.sv
// ============================================================================
// Module  : spi_pkg
// Purpose : Shared frame layout, op codes and FSM encoding for the SPI main
//           side controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int FRAME_W = 44;
    localparam int OP_W    = 2;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;

    localparam logic [OP_W-1:0] OP_READ  = 2'b00;
    localparam logic [OP_W-1:0] OP_WRITE = 2'b01;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TX   = 3'd1,
        ACC  = 3'd2,
        RX   = 3'd3,
        GAP  = 3'd4
    } spi_main_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_rr_arb.sv
// ============================================================================
// Module  : spi_rr_arb
// Purpose : Round-robin arbiter; search starts at the pointer, which moves to
//           one past the winner on each advance pulse.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_rr_arb #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_cand;
    logic             w_found;

    // Candidate index = (ptr + i) mod NUM_REQ; one extra bit avoids overflow.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found                   = 1'b1;
                grant[w_cand[IDX_W-1:0]]  = 1'b1;
                idx                       = w_cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            if (idx == IDX_W'(NUM_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_main_arb.sv
// ============================================================================
// Module  : spi_main_arb
// Purpose : SPI main controller sharing one spi_sub link among NUM_REQ
//           requesters; optional echo check under SPI_MAIN_ECHO_CHK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_main_arb
    import spi_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int GAP_CYC = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      sclk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [FRAME_W-1:0]        rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      cs_n,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int         GAP_W    = $clog2(GAP_CYC + 1);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_W - 1);

    spi_main_state_e       r_state;
    logic [5:0]            r_bit_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [FRAME_W-1:0]    r_tx_sh;
    logic [FRAME_W-2:0]    r_rx_sh;
    logic [ID_W-1:0]       r_id;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_grant_idx;
    logic                  w_can_accept;
    logic                  w_accept;
    spi_frame_t            w_req_frame;
    logic [FRAME_W-1:0]    w_rx_next;

    spi_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (sclk),
        .rst     (rst),
        .req     (req_valid),
        .advance (w_accept),
        .grant   (w_grant),
        .idx     (w_grant_idx)
    );

    assign w_can_accept = (r_state == IDLE) && (r_gap_cnt == '0);
    assign req_ready    = w_grant & {NUM_REQ{w_can_accept}};
    assign w_accept     = |(req_valid & req_ready);
    assign busy         = (r_state != IDLE);
    assign w_rx_next    = {r_rx_sh, miso};

    always_comb begin
        w_req_frame.op   = req_op[int'(w_grant_idx)*OP_W +: OP_W];
        w_req_frame.addr = req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
        w_req_frame.data = req_wdata[int'(w_grant_idx)*DATA_W +: DATA_W];
    end

`ifdef SPI_MAIN_ECHO_CHK_EN
    spi_frame_t r_sent;
    logic       w_echo_err;

    // Writes echo the whole frame; reads only echo the {op,addr} header.
    always_comb begin
        w_echo_err = 1'b0;
        case (r_sent.op)
            OP_WRITE: w_echo_err = (w_rx_next != r_sent);
            OP_READ:  w_echo_err = (w_rx_next[FRAME_W-1:DATA_W] != {r_sent.op, r_sent.addr});
            default:  w_echo_err = 1'b0;
        endcase
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_gap_cnt <= GAP_W'(GAP_CYC);
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_id      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
`ifdef SPI_MAIN_ECHO_CHK_EN
            r_sent    <= '0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef SPI_MAIN_ECHO_CHK_EN
            rsp_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                    if (w_accept) begin
                        r_tx_sh   <= w_req_frame;
                        r_id      <= w_grant_idx;
                        r_bit_cnt <= '0;
                        r_state   <= TX;
`ifdef SPI_MAIN_ECHO_CHK_EN
                        r_sent    <= w_req_frame;
`endif
                    end
                end
                TX: begin
                    r_tx_sh <= {r_tx_sh[FRAME_W-2:0], 1'b0};
                    if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt <= '0;
                        r_state   <= ACC;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                end
                // The sub performs its memory access on this posedge.
                ACC: begin
                    r_bit_cnt <= '0;
                    r_state   <= RX;
                end
                RX: begin
                    r_rx_sh <= w_rx_next[FRAME_W-2:0];
                    if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt <= '0;
                        rsp_data  <= w_rx_next;
                        rsp_id    <= r_id;
                        rsp_valid <= 1'b1;
                        r_gap_cnt <= GAP_W'(GAP_CYC);
                        r_state   <= GAP;
`ifdef SPI_MAIN_ECHO_CHK_EN
                        rsp_err   <= w_echo_err;
`endif
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                end
                GAP: begin
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_gap_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Launch on the falling edge so the sub sees half a cycle of setup.
    always_ff @(negedge sclk) begin
        cs_n <= !((r_state == TX) || (r_state == ACC) || (r_state == RX));
        mosi <= (r_state == TX) ? r_tx_sh[FRAME_W-1] : 1'b0;
    end

endmodule

`default_nettype wire
